// File: rtl/sram_confreg_resp_if.sv
// sram_confreg_resp_if: CPU data-SRAM bus between the pipeline (master) and
// the RAM/config-register responder (slave).
//
// Handshake: there is none. A request is presented for exactly one cycle
// with data_sram_en=1. data_sram_wen==4'b0000 marks a read, and any nonzero
// wen marks a byte-lane write. For a read, data_sram_rdata is valid on the
// cycle after the request edge. It then holds until the next read edge.
interface sram_confreg_resp_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/sram_confreg_resp.sv
// sram_confreg_resp: data-SRAM responder with a word RAM and a small bank of
// config/peripheral registers (LED, SWITCH, TIMER, SCRATCH, NUM).
//
// Optional feature macro: CONF_TIMER_EN. When this macro is defined, the
// free-running TIMER register is built. When it is undefined, offset 0x0008
// reads 0 and ignores writes.
//
// Read latency is one cycle with no stall. The RAM contents are not reset,
// but every register, including rdata, clears asynchronously on reset.
module sram_confreg_resp #(
    parameter int          RAM_AW    = 12,
    parameter logic [15:0] CONF_BASE = 16'hbfaf
) (
    input  logic                       clk,
    input  logic                       reset,
    sram_confreg_resp_if.slave         bus,
    input  logic [7:0]                 switch,
    output logic [15:0]                led,
    output logic [31:0]                num_data
);

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_SWITCH  = 16'h0004;
    localparam logic [15:0] OFF_TIMER   = 16'h0008;
    localparam logic [15:0] OFF_SCRATCH = 16'h000c;
    localparam logic [15:0] OFF_NUM     = 16'h0010;

    // Byte-lane merge: each lane whose enable bit is set takes the new data.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  lanes
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    logic              rd_acc;
    logic              wr_acc;
    logic              conf_hit;
    logic [15:0]       conf_off;
    logic [RAM_AW-1:0] ram_idx;

    logic [31:0]       ram [0:(2**RAM_AW)-1];

    logic [15:0]       led_q;
    logic [31:0]       scratch_q;
    logic [31:0]       num_q;
    logic [31:0]       timer_rd;
    logic [31:0]       conf_rd;
    logic [31:0]       rd_word;
    logic [31:0]       rdata_q;

    logic              led_we;
    logic              scratch_we;
    logic              num_we;

    // The access decode uses the upper half of the address to pick the region,
    // and the RAM index drops the high bits, so RAM addresses alias.
    assign rd_acc   = bus.data_sram_en && (bus.data_sram_wen == 4'b0000);
    assign wr_acc   = bus.data_sram_en && (bus.data_sram_wen != 4'b0000);
    assign conf_hit = (bus.data_sram_addr[31:16] == CONF_BASE);
    assign conf_off = bus.data_sram_addr[15:0];
    assign ram_idx  = bus.data_sram_addr[RAM_AW+1:2];

    assign led_we     = wr_acc && conf_hit && (conf_off == OFF_LED);
    assign scratch_we = wr_acc && conf_hit && (conf_off == OFF_SCRATCH);
    assign num_we     = wr_acc && conf_hit && (conf_off == OFF_NUM);

    // RAM write port. There is no reset on the storage. An access that
    // arrives while reset is asserted is dropped.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc && !conf_hit) begin
            ram[ram_idx] <= merge_bytes(ram[ram_idx], bus.data_sram_wdata,
                                        bus.data_sram_wen);
        end
    end

    // LED, SCRATCH and NUM registers, with byte-lane writes. LED keeps only lanes 0-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q     <= '0;
            scratch_q <= '0;
            num_q     <= '0;
        end else begin
            if (led_we) begin
                if (bus.data_sram_wen[0]) led_q[7:0]  <= bus.data_sram_wdata[7:0];
                if (bus.data_sram_wen[1]) led_q[15:8] <= bus.data_sram_wdata[15:8];
            end
            if (scratch_we) begin
                scratch_q <= merge_bytes(scratch_q, bus.data_sram_wdata,
                                         bus.data_sram_wen);
            end
            if (num_we) begin
                num_q <= merge_bytes(num_q, bus.data_sram_wdata,
                                     bus.data_sram_wen);
            end
        end
    end

`ifdef CONF_TIMER_EN
    logic        timer_we;
    logic [31:0] timer_q;

    assign timer_we = wr_acc && conf_hit && (conf_off == OFF_TIMER);
    assign timer_rd = timer_q;

    // TIMER counts every cycle. A write in that cycle replaces the increment,
    // and counting resumes from the written value on the next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else if (timer_we) begin
            timer_q <= merge_bytes(timer_q, bus.data_sram_wdata,
                                   bus.data_sram_wen);
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end
`else
    assign timer_rd = '0;
`endif

    // Config read mux. Unmapped offsets read as zero.
    always_comb begin
        conf_rd = '0;
        case (conf_off)
            OFF_LED:     conf_rd = {16'h0000, led_q};
            OFF_SWITCH:  conf_rd = {24'h000000, switch};
            OFF_TIMER:   conf_rd = timer_rd;
            OFF_SCRATCH: conf_rd = scratch_q;
            OFF_NUM:     conf_rd = num_q;
            default:     conf_rd = '0;
        endcase
    end

    // Region select for the read data.
    always_comb begin
        rd_word = ram[ram_idx];
        if (conf_hit) rd_word = conf_rd;
    end

    // The read data register loads only on a read edge and holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (rd_acc) begin
            rdata_q <= rd_word;
        end
    end

    assign bus.data_sram_rdata = rdata_q;
    assign led                 = led_q;
    assign num_data            = num_q;

endmodule

// File: tb/tb_sram_confreg_resp.sv
// tb_sram_confreg_resp: directed bench for sram_confreg_resp.
// Reads push their expected word into exp_q when they are issued. A monitor
// pops one entry on the falling edge after every read edge and compares it
// against rdata.
module tb_sram_confreg_resp;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  switch;
    logic [15:0] led;
    logic [31:0] num_data;

    sram_confreg_resp_if bus ();

    sram_confreg_resp #(
        .RAM_AW    (12),
        .CONF_BASE (16'hbfaf)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .switch   (switch),
        .led      (led),
        .num_data (num_data)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_issued;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Mark the cycles on which rdata carries a fresh read result.
    always @(posedge clk or posedge reset) begin
        if (reset) rd_issued <= 1'b0;
        else       rd_issued <= bus.data_sram_en && (bus.data_sram_wen == 4'b0000);
    end

    // Monitor: pop and compare one expected word per completed read.
    always @(negedge clk) begin
        if (rd_issued) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdata_unexpected: got 0x%08h expected no read", bus.data_sram_rdata);
            end else begin
                check(name_q.pop_front(), bus.data_sram_rdata, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.data_sram_en    = en;
        bus.data_sram_wen   = wen;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] wen);
        drive(1'b1, wen, addr, data);
    endtask

    task automatic rd(input string name, input logic [31:0] addr,
                      input logic [31:0] exp);
        drive(1'b1, 4'b0000, addr, 32'h0);
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    task automatic idle();
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset               = 1'b1;
        switch              = 8'h3c;
        bus.data_sram_en    = 1'b0;
        bus.data_sram_wen   = 4'b0000;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;

        repeat (2) @(negedge clk);
        check("reset_rdata", bus.data_sram_rdata, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);
        check("reset_num", num_data, 32'h0);
        reset = 1'b0;

        // RAM full write then readback, followed by a byte-lane update.
        wr(32'h0000_1000, 32'h1234_5678, 4'hf);
        rd("ram_word", 32'h0000_1000, 32'h1234_5678);
        wr(32'h0000_1000, 32'h0000_ab00, 4'b0010);
        rd("ram_byte", 32'h0000_1000, 32'h1234_ab78);

        // 0x4000 aliases to word 0 when RAM_AW=12.
        wr(32'h0000_4000, 32'hdead_beef, 4'hf);
        rd("ram_alias", 32'h0000_0000, 32'hdead_beef);

        // The TIMER write takes the edge. Later reads sample the pre-edge
        // value, which is the written value, then +1, then the wrap to zero.
        wr(32'hbfaf_0008, 32'hffff_fffe, 4'hf);
`ifdef CONF_TIMER_EN
        rd("timer_0", 32'hbfaf_0008, 32'hffff_fffe);
        rd("timer_1", 32'hbfaf_0008, 32'hffff_ffff);
        rd("timer_2", 32'hbfaf_0008, 32'h0000_0000);
`else
        rd("timer_0", 32'hbfaf_0008, 32'h0);
        rd("timer_1", 32'hbfaf_0008, 32'h0);
        rd("timer_2", 32'hbfaf_0008, 32'h0);
`endif

        // LED keeps only the low 16 bits.
        wr(32'hbfaf_0000, 32'hffff_5a5a, 4'hf);
        rd("led_read", 32'hbfaf_0000, 32'h0000_5a5a);
        check("led_port", {16'h0, led}, 32'h0000_5a5a);

        // SWITCH is read-only. Unmapped offsets read zero and ignore writes.
        wr(32'hbfaf_0004, 32'hffff_ffff, 4'hf);
        rd("switch_read", 32'hbfaf_0004, 32'h0000_003c);
        wr(32'hbfaf_0020, 32'hffff_ffff, 4'hf);
        rd("unmapped_read", 32'hbfaf_0020, 32'h0);

        // NUM and SCRATCH.
        wr(32'hbfaf_0010, 32'h0000_0011, 4'hf);
        wr(32'hbfaf_000c, 32'h0000_0022, 4'hf);
        rd("scratch_read", 32'hbfaf_000c, 32'h0000_0022);
        idle();
        check("num_port", num_data, 32'h0000_0011);
        rd("ram_pre_reset", 32'h0000_1000, 32'h1234_ab78);
        idle();
        idle();

        // Asynchronous reset between edges. The outputs clear with no clock edge.
        #2 reset = 1'b1;
        #1;
        check("async_rdata", bus.data_sram_rdata, 32'h0);
        check("async_led", {16'h0, led}, 32'h0);
        check("async_num", num_data, 32'h0);
        // A write issued while reset is held must be dropped.
        bus.data_sram_en    = 1'b1;
        bus.data_sram_wen   = 4'hf;
        bus.data_sram_addr  = 32'h0000_1000;
        bus.data_sram_wdata = 32'hbad0_bad0;
        @(posedge clk);
        @(negedge clk);
        bus.data_sram_en  = 1'b0;
        bus.data_sram_wen = 4'b0000;
        reset             = 1'b0;

        rd("ram_kept", 32'h0000_1000, 32'h1234_ab78);
        rd("scratch_cleared", 32'hbfaf_000c, 32'h0);
        rd("num_cleared", 32'hbfaf_0010, 32'h0);
        rd("led_cleared", 32'hbfaf_0000, 32'h0);
        idle();
        check("post_num", num_data, 32'h0);
        check("post_led", {16'h0, led}, 32'h0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
